// File: rtl/instr_decode_stage.sv
// instr_decode_stage: multicycle fetch/decode/exec/writeback controller
// for the 8-bit MIPS MPU; owns the PC, the IR and the 8x8 register file.
module instr_decode_stage #(
    parameter int IMEM_AW = 8,
    parameter int IMM_W   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_req,
    input  logic               imem_valid,
    input  logic [15:0]        imem_data,
    output logic [7:0]         ALU_src1,
    output logic [7:0]         ALU_src2,
    output logic [2:0]         ALU_fn,
    input  logic [7:0]         alu_result,
    input  logic               alu_zero,
    output logic [IMEM_AW-1:0] pc,
    output logic               retire,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'b00,
        S_DECODE = 2'b01,
        S_EXEC   = 2'b10,
        S_WB     = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [IMEM_AW-1:0] r_pc;
    logic [15:0]        r_ir;
    logic [7:0]         r_src1;
    logic [7:0]         r_src2;
    logic [2:0]         r_fn;
    logic [7:0]         r_result;
    logic [7:0]         r_rf [8];

    logic [2:0]         w_op;
    logic [2:0]         w_rd;
    logic [2:0]         w_rs;
    logic [2:0]         w_rt;
    logic [IMM_W-1:0]   w_imm;
    logic [7:0]         w_imm_sext;
    logic [IMEM_AW-1:0] w_pc_off;

    logic               w_is_rrr;
    logic               w_is_imm;
    logic               w_is_beq;

    logic [7:0]         w_rd_val;
    logic [7:0]         w_rs_val;
    logic [7:0]         w_rt_val;
    logic [7:0]         w_src1;
    logic [7:0]         w_src2;

    logic               w_fetch_fire;
    logic               w_rf_we;
    logic               w_beq_taken;
    logic [IMEM_AW-1:0] w_pc_next;
    logic               w_unused;

    // Instruction field extraction
    assign w_op  = r_ir[15:13];
    assign w_rd  = r_ir[12:10];
    assign w_rs  = r_ir[9:7];
    assign w_rt  = r_ir[6:4];
    assign w_imm = r_ir[IMM_W-1:0];

    assign w_imm_sext = {{(8-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    assign w_pc_off   = {{(IMEM_AW-IMM_W){w_imm[IMM_W-1]}}, w_imm};

    assign w_is_rrr = ~w_op[2];
    assign w_is_imm = w_op[2] & ~(&w_op);
    assign w_is_beq = &w_op;

    // R0 is hard-wired to zero on every read port
    assign w_rd_val = (w_rd == 3'd0) ? 8'd0 : r_rf[w_rd];
    assign w_rs_val = (w_rs == 3'd0) ? 8'd0 : r_rf[w_rs];
    assign w_rt_val = (w_rt == 3'd0) ? 8'd0 : r_rf[w_rt];

    always_comb begin
        w_src1 = w_rs_val;
        w_src2 = w_rt_val;
        unique case (1'b1)
            w_is_rrr: begin
                w_src1 = w_rs_val;
                w_src2 = w_rt_val;
            end
            w_is_imm: begin
                w_src1 = w_rs_val;
                w_src2 = w_imm_sext;
            end
            w_is_beq: begin
                w_src1 = w_rd_val;
                w_src2 = w_rs_val;
            end
            default: ;
        endcase
    end

    // ADD..LW write back; SW and BEQ do not
    assign w_rf_we     = (w_op <= 3'b101) && (w_rd != 3'd0);
    assign w_beq_taken = w_is_beq && (r_src1 == r_src2);
    assign w_pc_next   = w_beq_taken ? (r_pc + w_pc_off)
                                     : (r_pc + IMEM_AW'(1));

    assign w_fetch_fire = imem_req && imem_valid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_FETCH:  if (w_fetch_fire) w_state_next = S_DECODE;
            S_DECODE: w_state_next = S_EXEC;
            S_EXEC:   w_state_next = S_WB;
            S_WB:     w_state_next = S_FETCH;
            default:  w_state_next = S_FETCH;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        imem_req = 1'b0;
        retire   = 1'b0;
        unique case (r_state)
            S_FETCH: imem_req = run;
            S_WB:    retire   = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers and register file
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_fn     <= '0;
            r_result <= '0;
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (w_fetch_fire) r_ir <= imem_data;
                end
                S_DECODE: begin
                    r_fn   <= w_op;
                    r_src1 <= w_src1;
                    r_src2 <= w_src2;
                end
                S_EXEC: begin
                    r_result <= alu_result;
                end
                S_WB: begin
                    if (w_rf_we) r_rf[w_rd] <= r_result;
                    r_pc <= w_pc_next;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign ALU_src1  = r_src1;
    assign ALU_src2  = r_src2;
    assign ALU_fn    = r_fn;
    assign state_dbg = r_state;

    // Zero flag is not used for branch resolution here
    assign w_unused = alu_zero;

endmodule
